// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Package  : vga_timing_pkg
// Purpose  : 640x480@60 timing constants, pixel-byte field indices and FSM
//            state type shared by the vga_pixel_sink block.
// Revision : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    localparam logic [9:0] H_ACTIVE_END = 10'd639;
    localparam logic [9:0] HS_STA       = 10'd655;
    localparam logic [9:0] HS_END       = 10'd751;
    localparam logic [9:0] LINE         = 10'd799;
    localparam logic [9:0] V_ACTIVE_END = 10'd479;
    localparam logic [9:0] VS_STA       = 10'd489;
    localparam logic [9:0] VS_END       = 10'd491;
    localparam logic [9:0] SCREEN       = 10'd524;

    localparam int R_HI   = 7;
    localparam int R_LO   = 6;
    localparam int G_HI   = 5;
    localparam int G_LO   = 4;
    localparam int B_HI   = 3;
    localparam int B_LO   = 2;
    localparam int CTL_HI = 1;
    localparam int CTL_LO = 0;

    typedef enum logic [0:0] {
        ST_PREFILL = 1'b0,
        ST_RUN     = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/vga_pixel_sink_if.sv
`default_nettype none
// ============================================================================
// Interface : vga_pixel_sink_if
// Purpose   : PPU output handshake (stb/ack) carrying RGB222+ctl pixel bytes.
// Revision  : 1.0 - initial release
// ============================================================================
interface vga_pixel_sink_if;

    logic [7:0] data_i;
    logic       stb_i;
    logic       ack_i;

    modport master (
        output data_i,
        output stb_i,
        input  ack_i
    );

    modport slave (
        input  data_i,
        input  stb_i,
        output ack_i
    );

endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock byte FIFO with occupancy level; head is read
//            combinationally so the consumer can register it on the pop cycle.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [7:0]        din,
    output logic [7:0]        dout,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level
);

    logic [7:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_level;
    logic              w_do_push;
    logic              w_do_pop;

    assign full      = (r_level == (ADDR_W+1)'(DEPTH));
    assign empty     = (r_level == '0);
    assign level     = r_level;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + (ADDR_W+1)'(1);
                2'b01:   r_level <= r_level - (ADDR_W+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/vga_pixel_sink.sv
`default_nettype none
// ============================================================================
// Module   : vga_pixel_sink
// Purpose  : Accepts PPU pixel bytes, buffers them and drains one byte per
//            active pixel of a 640x480@60 raster; emits frame_start as PPU sync.
//            Define VGA_PIXEL_SINK_STATS_EN to add the underflow_cnt port.
// Revision : 1.0 - initial release
// ============================================================================
module vga_pixel_sink
    import vga_timing_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4,
    parameter int PREFILL = 8
) (
    input  logic                clk,
    input  logic                rst,
    vga_pixel_sink_if.slave     bus,
    output logic                frame_start,
    output logic [1:0]          vga_r,
    output logic [1:0]          vga_g,
    output logic [1:0]          vga_b,
    output logic                hsync,
    output logic                vsync,
    output logic                de,
    output logic [9:0]          sx,
    output logic [9:0]          sy
`ifdef VGA_PIXEL_SINK_STATS_EN
    ,
    output logic [15:0]         underflow_cnt
`endif
);

    state_t          r_state;
    state_t          w_state_next;
    logic            w_run;
    logic            r_ack;
    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic [ADDR_W:0] w_level;
    logic [7:0]      w_dout;
    logic            w_active;
    logic [9:0]      r_sx;
    logic [9:0]      r_sy;
    logic            r_frame_start;
    logic [1:0]      r_r;
    logic [1:0]      r_g;
    logic [1:0]      r_b;
    logic            r_hsync;
    logic            r_vsync;
    logic            r_de;
    logic            w_unused_ctl;

    // The registered ack masks the strobe so a held byte is taken only once.
    assign w_push     = bus.stb_i && !r_ack && !w_full;
    assign bus.ack_i  = r_ack;
    assign w_active   = (r_sx <= H_ACTIVE_END) && (r_sy <= V_ACTIVE_END);
    assign w_pop      = w_run && w_active && !w_empty;
    assign w_unused_ctl = ^w_dout[CTL_HI:CTL_LO];

    sync_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (bus.data_i),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty),
        .level (w_level)
    );

    always_ff @(posedge clk) begin
        if (!rst) r_state <= ST_PREFILL;
        else      r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_run        = 1'b0;
        case (r_state)
            ST_PREFILL: begin
                if (w_level >= (ADDR_W+1)'(PREFILL)) w_state_next = ST_RUN;
            end
            ST_RUN: begin
                w_run = 1'b1;
            end
            default: w_state_next = ST_PREFILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) r_ack <= 1'b0;
        else      r_ack <= w_push;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sx <= '0;
            r_sy <= '0;
        end else if (w_run) begin
            if (r_sx == LINE) begin
                r_sx <= '0;
                r_sy <= (r_sy == SCREEN) ? 10'd0 : r_sy + 10'd1;
            end else begin
                r_sx <= r_sx + 10'd1;
            end
        end
    end

    // frame_start is computed one pixel early so it coincides with sx==799,sy==524.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_frame_start <= 1'b0;
            r_r           <= 2'b00;
            r_g           <= 2'b00;
            r_b           <= 2'b00;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_de          <= 1'b0;
        end else if (w_run) begin
            r_frame_start <= (r_sx == LINE - 10'd1) && (r_sy == SCREEN);
            r_r           <= w_pop ? w_dout[R_HI:R_LO] : 2'b00;
            r_g           <= w_pop ? w_dout[G_HI:G_LO] : 2'b00;
            r_b           <= w_pop ? w_dout[B_HI:B_LO] : 2'b00;
            r_hsync       <= !((r_sx >= HS_STA) && (r_sx < HS_END));
            r_vsync       <= !((r_sy >= VS_STA) && (r_sy < VS_END));
            r_de          <= w_active;
        end
    end

`ifdef VGA_PIXEL_SINK_STATS_EN
    logic        w_underflow;
    logic [15:0] r_underflow_cnt;

    assign w_underflow   = w_run && w_active && w_empty;
    assign underflow_cnt = r_underflow_cnt;

    always_ff @(posedge clk) begin
        if (!rst)
            r_underflow_cnt <= '0;
        else if (w_underflow && (r_underflow_cnt != 16'hFFFF))
            r_underflow_cnt <= r_underflow_cnt + 16'd1;
    end
`endif

    assign frame_start = r_frame_start;
    assign vga_r       = r_r;
    assign vga_g       = r_g;
    assign vga_b       = r_b;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign de          = r_de;
    assign sx          = r_sx;
    assign sy          = r_sy;

endmodule
`default_nettype wire
